// File: rtl/npu_operand_feeder_pkg.sv
// Shared definitions for the operand feeder: activation address width and
// the FSM state encoding, visible to the layer controller and the bench.
package npu_operand_feeder_pkg;

  localparam int LOG2_ACT_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    NPU_FEED_IDLE     = 2'd0,
    NPU_FEED_FEED     = 2'd1,
    NPU_FEED_DRAIN    = 2'd2,
    NPU_FEED_WAIT_ACK = 2'd3
  } feed_state_e;

endpackage

// File: rtl/npu_feed_addr_gen.sv
// Operand index counter with the weight/activation base+i adders.
// Bases and length are captured on load; the index advances only on issue,
// so a hold simply freezes index and both addresses.
module npu_feed_addr_gen
  import npu_operand_feeder_pkg::*;
#(
  parameter int WT_ADDR_WIDTH  = 12,
  parameter int ACT_ADDR_WIDTH = LOG2_ACT_ADDR_WIDTH,
  parameter int LEN_WIDTH      = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [WT_ADDR_WIDTH-1:0]  wt_base,
  input  logic [ACT_ADDR_WIDTH-1:0] act_base,
  input  logic [LEN_WIDTH-1:0]      len,
  input  logic                      advance,
  output logic [WT_ADDR_WIDTH-1:0]  wt_addr,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  output logic                      first,
  output logic                      tc
);

  logic [WT_ADDR_WIDTH-1:0]  wt_base_q;
  logic [ACT_ADDR_WIDTH-1:0] act_base_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      idx_q;

  // Capture command fields on load, step the index on every issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_base_q  <= '0;
      act_base_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
    end else if (load) begin
      wt_base_q  <= wt_base;
      act_base_q <= act_base;
      len_q      <= len;
      idx_q      <= '0;
    end else if (advance) begin
      idx_q <= idx_q + LEN_WIDTH'(1);
    end
  end

  // Addresses wrap naturally at their own widths.
  assign wt_addr  = wt_base_q + WT_ADDR_WIDTH'(idx_q);
  assign act_addr = act_base_q + ACT_ADDR_WIDTH'(idx_q);
  assign first    = (idx_q == '0);
  assign tc       = (idx_q == (len_q - LEN_WIDTH'(1)));

endmodule

// File: rtl/npu_operand_feeder.sv
// Operand feeder for the neuron datapath: one dot-product command in,
// an aligned weight/activation stream framed by start_p/last_p out.
//
//   state     | meaning
//   IDLE      | ready for a command; zero-length commands complete here
//   FEED      | issuing paired reads, one per non-held cycle
//   DRAIN     | last operand pair on the output (last_p)
//   WAIT_ACK  | waiting for the neuron write acknowledge
module npu_operand_feeder
  import npu_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int WT_ADDR_WIDTH  = 12,
  parameter int ACT_ADDR_WIDTH = LOG2_ACT_ADDR_WIDTH,
  parameter int LEN_WIDTH      = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [WT_ADDR_WIDTH-1:0]  cmd_wt_base,
  input  logic [ACT_ADDR_WIDTH-1:0] cmd_act_base,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic                      cmd_wait_ack,
  input  logic                      feed_hold,
  output logic                      wt_rd_en,
  output logic [WT_ADDR_WIDTH-1:0]  wt_rd_addr,
  input  logic [DATA_WIDTH-1:0]     wt_rd_data,
  output logic                      act_rd_en,
  output logic [ACT_ADDR_WIDTH-1:0] act_rd_addr,
  input  logic [DATA_WIDTH-1:0]     act_rd_data,
  output logic                      mac_en,
  output logic                      start_p,
  output logic                      last_p,
  output logic [DATA_WIDTH-1:0]     weight_in,
  output logic [DATA_WIDTH-1:0]     act_in,
  input  logic                      wr_ack_p,
  output logic                      busy,
  output logic                      done_p
);

  feed_state_e state_q, state_d;
  logic accept, issue, idx_first, idx_tc, done_set;
  logic wait_ack_q, ack_seen_q;
  logic issue_q, first_q, last_q, done_q;

  assign accept = cmd_valid && (state_q == NPU_FEED_IDLE);
  assign issue  = (state_q == NPU_FEED_FEED) && !feed_hold;

  npu_feed_addr_gen #(
    .WT_ADDR_WIDTH (WT_ADDR_WIDTH),
    .ACT_ADDR_WIDTH(ACT_ADDR_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .wt_base (cmd_wt_base),
    .act_base(cmd_act_base),
    .len     (cmd_len),
    .advance (issue),
    .wt_addr (wt_rd_addr),
    .act_addr(act_rd_addr),
    .first   (idx_first),
    .tc      (idx_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= NPU_FEED_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; done_set marks every path that completes a command.
  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    case (state_q)
      NPU_FEED_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) done_set = 1'b1;
          else               state_d  = NPU_FEED_FEED;
        end
      end
      NPU_FEED_FEED: begin
        if (issue && idx_tc) state_d = NPU_FEED_DRAIN;
      end
      NPU_FEED_DRAIN: begin
        if (wait_ack_q) begin
          state_d = NPU_FEED_WAIT_ACK;
        end else begin
          state_d  = NPU_FEED_IDLE;
          done_set = 1'b1;
        end
      end
      NPU_FEED_WAIT_ACK: begin
        if (wr_ack_p || ack_seen_q) begin
          state_d  = NPU_FEED_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = NPU_FEED_IDLE;
    endcase
  end

  // Command flags, early-ack capture and the one-cycle read-latency alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_ack_q <= 1'b0;
      ack_seen_q <= 1'b0;
      issue_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (accept) begin
        wait_ack_q <= cmd_wait_ack;
        ack_seen_q <= 1'b0;
      end else if ((state_q == NPU_FEED_DRAIN) && wr_ack_p) begin
        ack_seen_q <= 1'b1;
      end
      issue_q <= issue;
      first_q <= issue && idx_first;
      last_q  <= issue && idx_tc;
      done_q  <= done_set;
    end
  end

  assign cmd_ready = (state_q == NPU_FEED_IDLE);
  assign busy      = (state_q != NPU_FEED_IDLE);
  assign wt_rd_en  = issue;
  assign act_rd_en = issue;
  assign mac_en    = issue_q;
  assign start_p   = issue_q && first_q;
  assign last_p    = issue_q && last_q;
  assign weight_in = issue_q ? wt_rd_data  : '0;
  assign act_in    = issue_q ? act_rd_data : '0;
  assign done_p    = done_q;

endmodule
